// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: NS rests green until a side-road or pedestrian
// request is latched, then runs yellow, all-red, EW green, yellow, all-red.
module intersection_controller #(
   parameter int unsigned NS_GREEN_MIN = 8,
   parameter int unsigned EW_GREEN_T   = 6,
   parameter int unsigned YELLOW_T     = 3,
   parameter int unsigned ALLRED_T     = 2,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ew_car,
   input  logic       ped_btn,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic       walk,
   output logic       req_pending,
   output logic [2:0] phase
);

   localparam logic [1:0] Red    = 2'b00;
   localparam logic [1:0] Yellow = 2'b01;
   localparam logic [1:0] Green  = 2'b10;

   localparam logic [CNT_W-1:0] NsMinLast  = CNT_W'(NS_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] EwLast     = CNT_W'(EW_GREEN_T - 1);
   localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_T - 1);

   typedef enum logic [2:0] {
      StNsGreen  = 3'd0,
      StNsYellow = 3'd1,
      StAllRedA  = 3'd2,
      StEwGreen  = 3'd3,
      StEwYellow = 3'd4,
      StAllRedB  = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             req_q, req_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StAllRedB;
         timer_q <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StNsGreen:  if (timer_q == NsMinLast && req_q) state_d = StNsYellow;
         StNsYellow: if (timer_q == YellowLast)         state_d = StAllRedA;
         StAllRedA:  if (timer_q == AllRedLast)         state_d = StEwGreen;
         StEwGreen:  if (timer_q == EwLast)             state_d = StEwYellow;
         StEwYellow: if (timer_q == YellowLast)         state_d = StAllRedB;
         StAllRedB:  if (timer_q == AllRedLast)         state_d = StNsGreen;
         default:                                       state_d = StAllRedB;
      endcase

      // NS green timer saturates so an idle main road never wraps back below the minimum
      if (state_d != state_q) begin
         timer_d = '0;
      end else if (state_q == StNsGreen && timer_q == NsMinLast) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + CNT_W'(1);
      end

      // A request arriving on the EW green entry edge must survive the clear
      if (ew_car || ped_btn) begin
         req_d = 1'b1;
      end else if (state_q == StAllRedA && state_d == StEwGreen) begin
         req_d = 1'b0;
      end else begin
         req_d = req_q;
      end
   end

   always_comb begin
      ns_light    = Red;
      ew_light    = Red;
      walk        = 1'b0;
      req_pending = req_q;
      phase       = state_q;
      case (state_q)
         StNsGreen:  ns_light = Green;
         StNsYellow: ns_light = Yellow;
         StEwGreen: begin
            ew_light = Green;
            walk     = 1'b1;
         end
         StEwYellow: ew_light = Yellow;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: a phase/elapsed-cycle reference model
// pushes the expected outputs per edge into a queue that is popped after each edge.
module tb_intersection_controller;

   localparam int NS_MIN = 8;
   localparam int EW_G   = 6;
   localparam int YEL    = 3;
   localparam int ARED   = 2;

   typedef struct {
      logic [1:0] ns;
      logic [1:0] ew;
      logic       walk;
      logic       req;
      logic [2:0] ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ew_car = 1'b0;
   logic       ped_btn = 1'b0;
   logic [1:0] ns_light, ew_light;
   logic       walk, req_pending;
   logic [2:0] phase;

   int checks = 0;
   int failures = 0;

   exp_t sb_q[$];

   int m_ph  = 5;
   int m_cnt = 0;
   bit m_req = 1'b0;

   int walk_run = 0;
   int ns_run   = 0;

   intersection_controller #(
      .NS_GREEN_MIN(NS_MIN),
      .EW_GREEN_T  (EW_G),
      .YELLOW_T    (YEL),
      .ALLRED_T    (ARED),
      .CNT_W       (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ew_car     (ew_car),
      .ped_btn    (ped_btn),
      .ns_light   (ns_light),
      .ew_light   (ew_light),
      .walk       (walk),
      .req_pending(req_pending),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int ph);
      case (ph)
         1, 4:    return YEL;
         2, 5:    return ARED;
         3:       return EW_G;
         default: return NS_MIN;
      endcase
   endfunction

   function automatic exp_t decode(input int ph, input bit req);
      exp_t e;
      e.ns   = (ph == 0) ? 2'b10 : (ph == 1) ? 2'b01 : 2'b00;
      e.ew   = (ph == 3) ? 2'b10 : (ph == 4) ? 2'b01 : 2'b00;
      e.walk = (ph == 3);
      e.req  = req;
      e.ph   = 3'(ph);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit c, input bit p);
      bit   ex;
      exp_t e;
      reset   = r;
      ew_car  = c;
      ped_btn = p;
      if (r) begin
         m_ph = 5; m_cnt = 0; m_req = 1'b0;
      end else begin
         ex = (m_ph == 0) ? (m_cnt >= NS_MIN - 1 && m_req) : (m_cnt == dur(m_ph) - 1);
         m_req = (c || p) ? 1'b1 : (ex && m_ph == 2) ? 1'b0 : m_req;
         if (ex) begin
            m_ph  = (m_ph + 1) % 6;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      sb_q.push_back(decode(m_ph, m_req));

      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("phase", 8'(phase), 8'(e.ph));
      chk("ns_light", 8'(ns_light), 8'(e.ns));
      chk("ew_light", 8'(ew_light), 8'(e.ew));
      chk("walk", 8'(walk), 8'(e.walk));
      chk("req_pending", 8'(req_pending), 8'(e.req));
      chk("both_not_red", 8'(ns_light != 2'b00 && ew_light != 2'b00), 8'd0);

      // Run-length checks independent of the model
      if (r) begin
         walk_run = 0;
         ns_run   = 0;
      end else begin
         if (walk) walk_run++;
         else if (walk_run != 0) begin
            chk("walk_len", 8'(walk_run), 8'(EW_G));
            walk_run = 0;
         end
         if (ns_light == 2'b10) ns_run++;
         else if (ns_run != 0) begin
            chk("ns_green_min", 8'(ns_run >= NS_MIN), 8'd1);
            ns_run = 0;
         end
      end
   endtask

   initial begin
      // Reset, then two all-red cycles before NS green
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      repeat (3) cycle(0, 0, 0);

      // Idle main road
      repeat (100) cycle(0, 0, 0);

      // Early request: pulse at NS green timer 2
      cycle(1, 0, 0);
      repeat (2) cycle(0, 0, 0);
      repeat (2) cycle(0, 0, 0);
      cycle(0, 1, 0);
      repeat (30) cycle(0, 0, 0);

      // Late request after a long NS dwell
      repeat (20) cycle(0, 0, 0);
      cycle(0, 0, 1);
      repeat (15) cycle(0, 0, 0);

      // Continuous side-road demand
      repeat (60) cycle(0, 1, 0);
      repeat (30) cycle(0, 0, 0);

      // Reset mid EW green with a request pending
      for (int i = 0; i < 40 && !(m_ph == 3 && m_cnt == 3); i++) cycle(0, 1, 0);
      chk("reached_ew_t3", 8'(phase == 3'd3 && walk), 8'd1);
      cycle(1, 0, 0);
      repeat (6) cycle(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences a two-road intersection: main road (NS) and side road (EW).
- Each road gets its own light output, using the team's light encoding: RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
- NS rests in green until a side-road car or pedestrian request arrives. The controller then runs a timed yellow, all-red, EW green, yellow, all-red sequence.
- Sits between the sensor/button inputs and the lamp drivers.

Parameters:
- NS_GREEN_MIN, 8, minimum NS green dwell in cycles (>=1).
- EW_GREEN_T, 6, fixed EW green duration in cycles (>=1).
- YELLOW_T, 3, yellow duration in cycles, used for both roads (>=1).
- ALLRED_T, 2, all-red clearance duration in cycles (>=1).
- CNT_W, 8, phase timer width; must hold max(all durations)-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- ew_car  input  1  side-road vehicle sensor, level or pulse.
- ped_btn  input  1  pedestrian crossing request, level or pulse.
- ns_light  output  2  NS lamp state, encoded RED/YELLOW/GREEN.
- ew_light  output  2  EW lamp state, encoded RED/YELLOW/GREEN.
- walk  output  1  pedestrian walk indication for crossing the NS road.
- req_pending  output  1  latched side/pedestrian request not yet served.
- phase  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5. Codes 6 and 7 are illegal and go to ALL_RED_B on the next edge.
- Reset (synchronous) sets:
  - state=ALL_RED_B, timer=0, req_pending=0.
  - Outputs therefore read ns_light=00, ew_light=00, walk=0, phase=5.
  - A reset asserted mid-sequence overrides any transition in that cycle.
- Timer behaviour:
  - Clears to 0 on every state change.
  - Otherwise increments each cycle.
  - In NS_GREEN it saturates at NS_GREEN_MIN-1, so it never wraps.
- Transitions (one state per edge, no skipping):
  - NS_GREEN -> NS_YELLOW when timer==NS_GREEN_MIN-1 and req_pending==1. Otherwise NS_GREEN holds indefinitely.
  - NS_YELLOW -> ALL_RED_A when timer==YELLOW_T-1.
  - ALL_RED_A -> EW_GREEN when timer==ALLRED_T-1.
  - EW_GREEN -> EW_YELLOW when timer==EW_GREEN_T-1. EW green ignores the sensors and is always exactly EW_GREEN_T cycles.
  - EW_YELLOW -> ALL_RED_B when timer==YELLOW_T-1.
  - ALL_RED_B -> NS_GREEN when timer==ALLRED_T-1.
- Request latch:
  - req_pending is set on any edge where ew_car or ped_btn is high.
  - It is cleared on the edge that enters EW_GREEN.
  - If a request is high on that same edge, set wins and req_pending stays 1.
  - Requests during EW_GREEN, EW_YELLOW or ALL_RED_B are held and served after the next NS minimum green.
- Output decode:
  - Outputs are a pure combinational decode of the state register, so they change the cycle after the transition edge.
  - ns_light=GREEN in NS_GREEN, YELLOW in NS_YELLOW, RED otherwise.
  - ew_light=GREEN in EW_GREEN, YELLOW in EW_YELLOW, RED otherwise.
  - walk=1 only in EW_GREEN.
  - Safety invariant: ns_light and ew_light are never both non-RED in the same cycle.
- Latency from request to EW green:
  - Best case (request already pending when NS_GREEN reaches its minimum): YELLOW_T+ALLRED_T cycles after NS_GREEN exits.
  - Worst case adds the remaining NS minimum dwell.

Test Plan:
1. Reset: hold reset 2 cycles, then release -> ns=00, ew=00, phase=5 for 2 cycles, then ns=10, phase=0; walk=0 throughout.
2. Idle: no requests for 100 cycles after reaching NS_GREEN -> ns stays 10, ew stays 00, req_pending=0, timer saturates at 7 and never wraps.
3. Early request: one-cycle ew_car pulse at NS_GREEN timer=2 -> req_pending=1; expected sequence is:
   - ns=10 for 8 total cycles;
   - ns=01 for 3 cycles;
   - all red for 2 cycles;
   - ew=10 with walk=1 for exactly 6 cycles, with req_pending=0 from EW_GREEN entry;
   - ew=01 for 3 cycles;
   - all red for 2 cycles;
   - back to ns=10 with no further cycle.
4. Late request: ped_btn pulse at NS_GREEN cycle 20 -> NS_YELLOW on the next edge; EW_GREEN entered 5 cycles after that.
5. Request during service: ew_car held high continuously -> req_pending stays 1 across EW_GREEN entry (set wins); the controller cycles repeatedly with exactly 8 NS green cycles each loop; the no-both-non-RED check holds every cycle.
6. Reset mid-operation: assert reset at EW_GREEN timer=3 with req_pending=1 -> next cycle phase=5, both lights 00, walk=0, req_pending=0; normal restart into NS_GREEN after 2 cycles.
